// File: rtl/direction_arbiter.sv
// Purpose : arbitrates three 5-bit {mode, dir[3:0]} command sources onto one direction path.
//           Fixed priority sig1 > sig2 > sig3, minimum grant hold, glitch-tolerant release.
// Latency : one cycle; inputs sampled at an edge are visible on the registered outputs after it.
// Backpressure: none; sources are level commands and losers simply wait while still asserted.
// Ports   : clk, reset_n (async, active-low); sig1..sig3 command inputs (all-zero = no request);
//           direction_out granted direction; grant one-hot owner (bit0 = sig1); busy not idle;
//           mode_out toggles on each owner mode rising edge; mode_pulse one-cycle toggle strobe.
module direction_arbiter #(
    parameter int HOLD_CYCLES  = 4,
    parameter int IDLE_TIMEOUT = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] sig1,
    input  logic [4:0] sig2,
    input  logic [4:0] sig3,
    output logic [3:0] direction_out,
    output logic [2:0] grant,
    output logic       busy,
    output logic       mode_out,
    output logic       mode_pulse
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int ZW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [ZW-1:0] ZERO_LAST = ZW'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state, w_state_n;
    logic [2:0]      r_grant, w_grant_n;
    logic [HW-1:0]   r_hold, w_hold_n;
    logic [ZW-1:0]   r_zero, w_zero_n;
    logic [3:0]      r_dir, w_dir_n;
    logic            r_busy;
    logic            r_mode_prev, w_mode_prev_n;
    logic            r_mode, w_mode_n;
    logic            r_pulse, w_pulse_n;

    logic [2:0]      w_req;
    logic [2:0]      w_win;
    logic [2:0]      w_hi_req;
    logic [2:0]      w_hi_win;
    logic [4:0]      w_win_sig;
    logic [4:0]      w_hi_sig;
    logic [4:0]      w_own_sig;
    logic            w_own_req;

    function automatic logic [4:0] f_sel(input logic [2:0] g, input logic [4:0] a,
                                         input logic [4:0] b, input logic [4:0] c);
        return ({5{g[0]}} & a) | ({5{g[1]}} & b) | ({5{g[2]}} & c);
    endfunction

    assign w_req     = {(sig3 != 5'd0), (sig2 != 5'd0), (sig1 != 5'd0)};
    // x & -x isolates the lowest set bit, i.e. the highest-priority requester.
    assign w_win     = w_req & (~w_req + 3'd1);
    // grant - 1 on a one-hot grant masks exactly the sources above the owner.
    assign w_hi_req  = w_req & (r_grant - 3'd1);
    assign w_hi_win  = w_hi_req & (~w_hi_req + 3'd1);
    assign w_win_sig = f_sel(w_win, sig1, sig2, sig3);
    assign w_hi_sig  = f_sel(w_hi_win, sig1, sig2, sig3);
    assign w_own_sig = f_sel(r_grant, sig1, sig2, sig3);
    assign w_own_req = (w_own_sig != 5'd0);

    always_comb begin
        w_state_n     = r_state;
        w_grant_n     = r_grant;
        w_hold_n      = r_hold;
        w_zero_n      = r_zero;
        w_dir_n       = 4'd0;
        w_mode_prev_n = r_mode_prev;
        w_mode_n      = r_mode;
        w_pulse_n     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req != 3'd0) begin
                    w_state_n     = S_OWN;
                    w_grant_n     = w_win;
                    w_hold_n      = HOLD_LOAD;
                    w_zero_n      = '0;
                    w_mode_prev_n = 1'b0;
                    w_dir_n       = w_win_sig[3:0];
                end
            end
            S_OWN: begin
                // Preemption wins over owner loss once the hold has expired.
                if ((r_hold == '0) && (w_hi_req != 3'd0)) begin
                    w_grant_n     = w_hi_win;
                    w_hold_n      = HOLD_LOAD;
                    w_mode_prev_n = 1'b0;
                    w_dir_n       = w_hi_sig[3:0];
                end else begin
                    if (r_hold != '0) begin
                        w_hold_n = r_hold - HW'(1);
                    end
                    w_mode_prev_n = w_own_sig[4];
                    if (!w_own_req) begin
                        if (IDLE_TIMEOUT == 1) begin
                            w_state_n = S_IDLE;
                            w_grant_n = 3'd0;
                            w_hold_n  = '0;
                            w_zero_n  = '0;
                        end else begin
                            w_state_n = S_DRAIN;
                            w_zero_n  = ZW'(1);
                        end
                    end else begin
                        w_dir_n = w_own_sig[3:0];
                        if (w_own_sig[4] && !r_mode_prev) begin
                            w_mode_n  = ~r_mode;
                            w_pulse_n = 1'b1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                // The hold counter and mode history are frozen while draining.
                if (w_own_req) begin
                    w_state_n = S_OWN;
                    w_zero_n  = '0;
                    w_dir_n   = w_own_sig[3:0];
                end else if (r_zero == ZERO_LAST) begin
                    w_state_n = S_IDLE;
                    w_grant_n = 3'd0;
                    w_hold_n  = '0;
                    w_zero_n  = '0;
                end else begin
                    w_zero_n = r_zero + ZW'(1);
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_grant_n = 3'd0;
                w_hold_n  = '0;
                w_zero_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_grant     <= 3'd0;
            r_hold      <= '0;
            r_zero      <= '0;
            r_dir       <= 4'd0;
            r_busy      <= 1'b0;
            r_mode_prev <= 1'b0;
            r_mode      <= 1'b0;
            r_pulse     <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_grant     <= w_grant_n;
            r_hold      <= w_hold_n;
            r_zero      <= w_zero_n;
            r_dir       <= w_dir_n;
            r_busy      <= (w_state_n != S_IDLE);
            r_mode_prev <= w_mode_prev_n;
            r_mode      <= w_mode_n;
            r_pulse     <= w_pulse_n;
        end
    end

    assign direction_out = r_dir;
    assign grant         = r_grant;
    assign busy          = r_busy;
    assign mode_out      = r_mode;
    assign mode_pulse    = r_pulse;

endmodule

// File: tb/tb_direction_arbiter.sv
// Purpose : self-checking bench for direction_arbiter; directed scenarios plus random traffic.
// Latency : reference model advances at each rising edge, outputs compared on the falling edge.
// Backpressure: not applicable; stimulus is free-running level commands.
module tb_direction_arbiter;

    localparam int HOLD = 4;
    localparam int TMO  = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] sig1, sig2, sig3;
    logic [3:0] direction_out;
    logic [2:0] grant;
    logic       busy, mode_out, mode_pulse;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner index (0 = none), whether draining, OWN cycles
    // completed under the current grant, and the current run of zero cycles.
    int         m_owner;
    bit         m_drain;
    int         m_age;
    int         m_zrun;
    bit         m_prev, m_mode, m_pulse;
    logic [3:0] m_dir;

    direction_arbiter #(.HOLD_CYCLES(HOLD), .IDLE_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sig1         (sig1),
        .sig2         (sig2),
        .sig3         (sig3),
        .direction_out(direction_out),
        .grant        (grant),
        .busy         (busy),
        .mode_out     (mode_out),
        .mode_pulse   (mode_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_grant();
        return (m_owner == 0) ? 0 : (1 << (m_owner - 1));
    endfunction

    task automatic model_reset();
        m_owner = 0; m_drain = 0; m_age = 0; m_zrun = 0;
        m_prev = 0; m_mode = 0; m_pulse = 0; m_dir = 4'd0;
    endtask

    task automatic model_step();
        logic [4:0] s [4];
        int first;
        int hp;
        s[0] = 5'd0; s[1] = sig1; s[2] = sig2; s[3] = sig3;
        first = 0;
        for (int i = 3; i >= 1; i--) if (s[i] != 5'd0) first = i;
        m_pulse = 0;
        if (m_owner == 0) begin
            m_dir = 4'd0;
            if (first != 0) begin
                m_owner = first; m_drain = 0; m_age = 0; m_zrun = 0; m_prev = 0;
                m_dir = s[first][3:0];
            end
        end else if (!m_drain) begin
            hp = 0;
            for (int i = m_owner - 1; i >= 1; i--) if (s[i] != 5'd0) hp = i;
            if (hp != 0 && m_age >= HOLD - 1) begin
                m_owner = hp; m_age = 0; m_prev = 0;
                m_dir = s[hp][3:0];
            end else begin
                m_age++;
                if (s[m_owner] == 5'd0) begin
                    m_prev = 0; m_dir = 4'd0; m_zrun = 1;
                    if (m_zrun >= TMO) begin
                        m_owner = 0; m_zrun = 0;
                    end else begin
                        m_drain = 1;
                    end
                end else begin
                    if (s[m_owner][4] && !m_prev) begin
                        m_mode = !m_mode; m_pulse = 1;
                    end
                    m_prev = s[m_owner][4];
                    m_dir  = s[m_owner][3:0];
                end
            end
        end else begin
            if (s[m_owner] != 5'd0) begin
                m_drain = 0; m_zrun = 0;
                m_dir = s[m_owner][3:0];
            end else begin
                m_dir = 4'd0;
                m_zrun++;
                if (m_zrun >= TMO) begin
                    m_owner = 0; m_drain = 0; m_zrun = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("grant", grant, exp_grant());
        chk("direction_out", direction_out, m_dir);
        chk("busy", busy, (m_owner != 0) ? 1 : 0);
        chk("mode_out", mode_out, m_mode);
        chk("mode_pulse", mode_pulse, m_pulse);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Hand-computed value checked against both the DUT and the model.
    task automatic lit(input string name, input int dut_v, input int model_v, input int l);
        chk(name, dut_v, l);
        chk({name, "_model"}, model_v, l);
    endtask

    task automatic set_sig(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        sig1 = a; sig2 = b; sig3 = c;
    endtask

    task automatic clear_idle();
        set_sig(5'd0, 5'd0, 5'd0);
        repeat (3) tick();
        lit("idle_grant", grant, exp_grant(), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        set_sig(5'd0, 5'd0, 5'd0);
        model_reset();
        #12;
        chk("reset_grant", grant, 0);
        chk("reset_dir", direction_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_mode", mode_out, 0);
        chk("reset_pulse", mode_pulse, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Single request
        set_sig(5'd0, 5'b00101, 5'd0);
        tick();
        lit("single_grant", grant, exp_grant(), 3'b010);
        lit("single_dir", direction_out, m_dir, 4'b0101);
        lit("single_busy", busy, (m_owner != 0) ? 1 : 0, 1);
        lit("single_mode", mode_out, m_mode, 0);
        clear_idle();

        // Simultaneous requests
        set_sig(5'b00001, 5'b00010, 5'b00100);
        tick();
        lit("simul_grant", grant, exp_grant(), 3'b001);
        lit("simul_dir", direction_out, m_dir, 4'b0001);
        clear_idle();

        // Preemption after the minimum hold
        set_sig(5'd0, 5'd0, 5'b01000);
        tick();
        lit("pre_grant0", grant, exp_grant(), 3'b100);
        set_sig(5'b00010, 5'd0, 5'b01000);
        for (int k = 1; k < HOLD; k++) begin
            tick();
            lit("pre_hold_grant", grant, exp_grant(), 3'b100);
        end
        tick();
        lit("pre_grant", grant, exp_grant(), 3'b001);
        lit("pre_dir", direction_out, m_dir, 4'b0010);
        clear_idle();

        // Drain: short glitch recovers, long gap releases
        set_sig(5'b00001, 5'b00110, 5'd0);
        tick();
        lit("drain_grant0", grant, exp_grant(), 3'b001);
        tick();
        sig1 = 5'd0;
        tick();
        lit("drain_dir0", direction_out, m_dir, 0);
        lit("drain_grant_hold", grant, exp_grant(), 3'b001);
        sig1 = 5'b00001;
        tick();
        lit("drain_dir_back", direction_out, m_dir, 1);
        sig1 = 5'd0;
        tick();
        lit("drain2_grant", grant, exp_grant(), 3'b001);
        tick();
        lit("release_grant", grant, exp_grant(), 0);
        lit("release_busy", busy, (m_owner != 0) ? 1 : 0, 0);
        tick();
        lit("regrant_grant", grant, exp_grant(), 3'b010);
        lit("regrant_dir", direction_out, m_dir, 4'b0110);
        clear_idle();

        // Mode toggling: bit4 sequence 0,1,1,0,1
        set_sig(5'b00001, 5'd0, 5'd0);
        tick();
        lit("mode_m0", mode_out, m_mode, 0);
        sig1 = 5'b10001;
        tick();
        lit("mode_m1", mode_out, m_mode, 1);
        lit("mode_p1", mode_pulse, m_pulse, 1);
        tick();
        lit("mode_m2", mode_out, m_mode, 1);
        lit("mode_p2", mode_pulse, m_pulse, 0);
        sig1 = 5'b00001;
        tick();
        lit("mode_p3", mode_pulse, m_pulse, 0);
        sig1 = 5'b10001;
        tick();
        lit("mode_m4", mode_out, m_mode, 0);
        lit("mode_p4", mode_pulse, m_pulse, 1);
        tick();
        lit("mode_p5", mode_pulse, m_pulse, 0);

        // Asynchronous reset in the middle of ownership
        sig1 = 5'b00011;
        tick();
        lit("rst_own_dir", direction_out, m_dir, 4'b0011);
        sig1 = 5'b10011;
        tick();
        lit("rst_own_mode", mode_out, m_mode, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_grant", grant, 0);
        chk("arst_dir", direction_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_mode", mode_out, 0);
        chk("arst_pulse", mode_pulse, 0);
        model_reset();
        set_sig(5'd0, 5'd0, 5'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Random traffic, values held for a few cycles so holds and drains occur
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0)
                sig1 = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if ($urandom_range(0, 5) == 0)
                sig2 = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if ($urandom_range(0, 5) == 0)
                sig3 = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/direction_arbiter.md
# direction_arbiter

Arbitrates three 5-bit direction/mode command sources ({mode, dir[3:0]}; all-zero means no request) for the single direction path feeding the motion logic. Grants one source at a time with fixed priority sig1 > sig2 > sig3, a minimum grant hold, and a release timeout to suppress glitches. Converts the granted source's mode bit into a registered mode toggle and a one-cycle pulse. All outputs are registered.

## Interface
Parameters:
- HOLD_CYCLES, 4, minimum cycles a grant is held before a higher-priority source may preempt (>= 1)
- IDLE_TIMEOUT, 2, consecutive all-zero owner cycles that release the grant (>= 1)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- sig1  in  5  source 1 command; [4] mode request, [3:0] direction; highest priority
- sig2  in  5  source 2 command; same format
- sig3  in  5  source 3 command; same format; lowest priority
- direction_out  out  4  granted direction
- grant  out  3  one-hot owner (bit0 = sig1); 0 when idle
- busy  out  1  high when state is not IDLE
- mode_out  out  1  mode level; toggles on each owner mode rising edge
- mode_pulse  out  1  one-cycle strobe on each mode_out toggle

One clock; reset is asynchronous and active-low.

## Operation
- req_i = (sig_i != 0). Priority winner = lowest-index active request.
- States: IDLE, OWN, DRAIN.
- IDLE: grant = 0, direction_out = 0. Any req -> OWN with grant = winner; hold_cnt = HOLD_CYCLES-1.
- OWN: direction_out = owner sig[3:0]. hold_cnt decrements each cycle to 0, then saturates.
  - hold_cnt == 0 and a higher-priority req active -> stay OWN, grant = that source, hold_cnt reloaded. Owner's own req takes no part in this check.
  - Owner req == 0 -> zero counting starts. IDLE_TIMEOUT == 1 -> IDLE directly. Otherwise -> DRAIN.
  - Preemption is checked before owner loss.
- DRAIN: grant unchanged, direction_out = 0, hold_cnt frozen.
  - Owner req returns -> OWN; the zero count clears.
  - IDLE_TIMEOUT consecutive zero cycles, including the cycle that entered DRAIN -> IDLE.
  - Other requests are ignored in DRAIN.
- Mode tracking: mode_prev is cleared on every grant change, including a grant from IDLE. In OWN, owner sig[4] == 1 with mode_prev == 0 -> mode_out inverts and mode_pulse = 1 for one cycle. mode_prev <= owner sig[4] each OWN cycle and holds in DRAIN. A new owner arriving with sig[4] = 1 therefore toggles once.
- Widths: hold and timeout counters are $clog2(param+1) bits. All-zero input ties are impossible because zero means no request.

## Timing
- Reset (reset_n low, any state, immediate): state IDLE, direction_out 0, grant 0, busy 0, mode_out 0, mode_pulse 0, counters 0, mode_prev 0.
- Latency: inputs are sampled at edge N; the response is visible after edge N (one cycle). There is no combinational input-to-output path.
- A minimum hold of exactly HOLD_CYCLES OWN cycles before preemption. Hold counter values during OWN cycles: HOLD_CYCLES-1 … 0.
- Re-entering arbitration after a release costs one IDLE cycle.
- Direction changes from the owner pass through every OWN cycle with no hold.

## Test plan
- Reset: hold reset_n = 0, release, then pull reset_n low during OWN with sig1 = 5'b00011 -> all outputs 0 immediately, without waiting for a clock edge.
- Single request: from IDLE, sig2 = 5'b00101 -> after the next edge grant = 3'b010, direction_out = 4'b0101, busy = 1, mode_out = 0.
- Simultaneous: all three sources nonzero from IDLE (sig1 = 5'b00001, sig2 = 5'b00010, sig3 = 5'b00100) -> grant = 3'b001, direction_out = 4'b0001.
- Preemption, HOLD_CYCLES = 4: sig3 = 5'b01000 is granted; sig1 = 5'b00010 is asserted in the first OWN cycle and held -> grant stays 3'b100 for 4 cycles, then 3'b001 with direction_out = 4'b0010.
- Drain, IDLE_TIMEOUT = 2, owner sig1, sig2 = 5'b00110 pending:
  - sig1 zero for 1 cycle, then 5'b00001 -> direction_out 0 for that cycle, grant stays 3'b001, then direction 1 returns.
  - sig1 zero for 2 cycles -> grant 0 and busy 0 for one cycle, then grant = 3'b010 with direction_out = 4'b0110.
- Mode: owner sig1 bit4 sequence 0, 1, 1, 0, 1 with dir = 4'b0001 -> mode_out goes 0 -> 1 -> 0 (two toggles), with mode_pulse high for exactly one cycle at each toggle.
